// File: rtl/axi4_read_test.sv
// AXI4 read-burst test master: issues one INCR burst and checks every returned
// beat against the rotating pattern written by the companion write tester.
module axi4_read_test #(
   parameter logic [31:0] ADDR    = 32'h0000_0000,
   parameter logic [31:0] PATTERN = 32'h1234_5678,
   parameter int          BEATS   = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_count,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arlock,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        awvalid,
   output logic        wvalid,
   output logic        bready
);

   // state  | meaning
   // IDLE   | waiting for start; done/error/err_count hold last run's result
   // ADDR   | arvalid asserted until the AR handshake
   // DATA   | rready asserted; each accepted beat is checked
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   localparam logic [7:0] LAST_CNT = 8'(BEATS - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] expected;
   logic        beat_bad;

   assign araddr  = ADDR;
   assign arlen   = LAST_CNT;
   assign arsize  = 3'h2;
   assign arburst = 2'b01;
   assign arcache = 4'h0;
   assign arprot  = 3'h0;
   assign arlock  = 1'b0;
   assign awvalid = 1'b0;
   assign wvalid  = 1'b0;
   assign bready  = 1'b0;

   // rlast must coincide exactly with the final beat of the burst
   always_comb begin
      beat_bad = (rdata != expected) || (rresp != 2'b00) || (rlast != (cnt == 8'd0));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_count <= 8'd0;
         cnt       <= LAST_CNT;
         expected  <= PATTERN;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_ADDR;
                  arvalid   <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  err_count <= 8'd0;
               end
            end
            ST_ADDR: begin
               if (arvalid && arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (rvalid && rready) begin
                  if (beat_bad) begin
                     error <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
                  if (cnt == 8'd0) begin
                     rready   <= 1'b0;
                     done     <= 1'b1;
                     cnt      <= LAST_CNT;
                     expected <= PATTERN;
                     state    <= ST_IDLE;
                  end else begin
                     cnt      <= cnt - 8'd1;
                     expected <= {expected[3:0], expected[31:4]};
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               arvalid <= 1'b0;
               rready  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_read_test.sv
// Bench for axi4_read_test: directed slave bursts, scoreboard queues checked by a monitor.
module tb_axi4_read_test;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        done, error;
   logic [7:0]  err_count;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arlock, arvalid, rready;
   logic        arready = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic [1:0]  rresp = 2'b00;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        awvalid, wvalid, bready;

   always #5 clk = ~clk;

   axi4_read_test dut (
      .clk(clk), .rstn(rstn), .start(start), .done(done), .error(error),
      .err_count(err_count), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arcache(arcache), .arprot(arprot), .arlock(arlock),
      .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready), .awvalid(awvalid),
      .wvalid(wvalid), .bready(bready)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       err;
      logic [7:0] cnt;
      int         beats;
   } res_t;

   res_t        exp_res[$];
   logic [31:0] exp_araddr[$];

   // seed 0x12345678 rotated right 4 bits per beat
   logic [31:0] pat [16] = '{
      32'h12345678, 32'h81234567, 32'h78123456, 32'h67812345,
      32'h56781234, 32'h45678123, 32'h34567812, 32'h23456781,
      32'h12345678, 32'h81234567, 32'h78123456, 32'h67812345,
      32'h56781234, 32'h45678123, 32'h34567812, 32'h23456781};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops expectations whenever the DUT presents an AR handshake or a done edge
   int   beat_cnt = 0;
   int   ar_cnt = 0;
   logic done_q = 1'b0;
   logic ar_pend = 1'b0;

   always @(negedge clk) begin
      if (rstn) begin
         if (ar_pend) check("arvalid_stable", arvalid, 1);
         ar_pend = arvalid && !arready;
         if (arvalid && arready) begin
            ar_cnt++;
            beat_cnt = 0;
            if (exp_araddr.size() == 0) begin
               check("unexpected_ar", 1, 0);
            end else begin
               check("araddr", araddr, exp_araddr.pop_front());
               check("arlen", arlen, 32'h0F);
               check("arsize_arburst", {arsize, arburst}, {3'h2, 2'b01});
               check("ar_misc", {arcache, arprot, arlock}, 0);
            end
         end
         if (rvalid && rready) beat_cnt++;
         if (done && !done_q) begin
            if (exp_res.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               res_t r;
               r = exp_res.pop_front();
               check("error", error, r.err);
               check("err_count", err_count, r.cnt);
               check("beats_accepted", beat_cnt, r.beats);
            end
         end
         done_q = done;
      end else begin
         ar_pend = 1'b0;
         done_q  = 1'b0;
      end
   end

   task automatic run_burst(input int ar_delay, input int max_gap, input int bad_data_beat,
                            input int bad_resp_beat, input bit early_last, input int abort_after,
                            input bit start_in_data, input bit exp_err, input int exp_cnt);
      res_t r;
      bit   hs;
      int   to;
      int   gap;
      exp_araddr.push_back(32'h0);
      if (abort_after < 0) begin
         r.err = exp_err; r.cnt = 8'(exp_cnt); r.beats = 16;
         exp_res.push_back(r);
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("clr_on_accept", {done, error, err_count}, 0);
      check("arvalid_after_start", arvalid, 1);
      repeat (ar_delay) begin @(posedge clk); #1; end
      arready = 1'b1;
      @(posedge clk); #1 arready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == abort_after) begin
            rvalid = 1'b0;
            rstn = 1'b0;
            #1 check("abort_outputs", {arvalid, rready, done, error}, 0);
            return;
         end
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         rvalid = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
         rdata  = pat[i] ^ ((i == bad_data_beat) ? 32'h1 : 32'h0);
         rresp  = (i == bad_resp_beat) ? 2'b10 : 2'b00;
         rlast  = early_last ? (i == 14) : (i == 15);
         rvalid = 1'b1;
         if (start_in_data && i == 3) start = 1'b1;
         hs = 0;
         to = 0;
         while (!hs && to < 100) begin
            @(negedge clk); hs = rready;
            @(posedge clk); #1 start = 1'b0;
            to++;
         end
         if (!hs) begin
            check("beat_timeout", 0, 1);
            rvalid = 1'b0;
            return;
         end
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      check("done_latency", done, 1);
      repeat (2) @(posedge clk);
      #1 check("done_hold", done, 1);
   endtask

   int ar_before;

   initial begin
      repeat (3) @(posedge clk);
      #1 check("reset_outputs", {arvalid, rready, done, error, err_count}, 0);
      check("tieoffs", {awvalid, wvalid, bready}, 0);
      rstn = 1'b1;
      // clean, zero-wait
      run_burst(0, 0, -1, -1, 0, -1, 0, 0, 0);
      // backpressure on AR and R
      run_burst(3, 4, -1, -1, 0, -1, 0, 0, 0);
      // single data corruption on beat 5
      run_burst(0, 0, 5, -1, 0, -1, 0, 1, 1);
      // data corruption plus bad rresp on beat 0
      run_burst(0, 1, 5, 0, 0, -1, 0, 1, 2);
      // rlast on beat 14 instead of 15
      run_burst(0, 0, -1, -1, 1, -1, 0, 1, 2);
      // rerun after a failing run
      run_burst(1, 2, -1, -1, 0, -1, 0, 0, 0);
      // reset after beat 7, then a fresh run with a stray start during DATA
      run_burst(0, 0, -1, -1, 0, 8, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      ar_before = ar_cnt;
      run_burst(0, 1, -1, -1, 0, -1, 1, 0, 0);
      repeat (5) @(posedge clk);
      #1 check("single_ar_after_stray_start", ar_cnt - ar_before, 1);
      check("ar_queue_empty", exp_araddr.size(), 0);
      check("res_queue_empty", exp_res.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/axi4_read_test.md
Name: axi4_read_test

Overview:
- AXI4 read-burst test master, paired with the existing write-burst test master.
- On start, issues one INCR burst read of BEATS 32-bit words from ADDR.
- Checks every returned beat against the same rotating pattern the write tester stores (seed PATTERN, rotated right 4 bits per beat), plus RLAST placement and RRESP.
- Reports done/error to the board-level test harness.

Parameters:
- ADDR, 32'h00000000, burst start address (araddr).
- PATTERN, 32'h12345678, expected data for beat 0.
- BEATS, 16, burst length in beats (1..256); arlen = BEATS-1.

Ports:
- clk  in  1  sole clock; all state on posedge clk.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  level or pulse; sampled only in IDLE.
- done  out  1  set when a burst completes; cleared when the next start is accepted.
- error  out  1  sticky failure flag for the current run; cleared when the next start is accepted.
- err_count  out  8  mismatched beats in the current run; saturates at 255.
- m  axi4_ifc.master  —  read channels used (AR*, R*); AW/W/B outputs tied off: awvalid=0, wvalid=0, bready=0.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; arvalid=0, rready=0, done=0, error=0, err_count=0; beat counter=BEATS-1; expected=PATTERN.
  - Reset mid-burst aborts immediately; no done pulse.
- Constant AR fields: araddr=ADDR, arlen=BEATS-1, arsize=3'h2, arburst=2'b01, arcache=0, arprot=0, arlock=0.
- arvalid and rready are registered outputs.
- IDLE:
  - start=1 -> ADDR.
  - arvalid=1 from the next cycle.
  - done, error, err_count clear on the same edge.
- ADDR:
  - arvalid held 1 until a cycle where arvalid&arready.
  - On that edge: arvalid=0, rready=1, -> DATA.
- DATA:
  - rready held 1 throughout.
  - Beat accepted on rvalid&rready.
  - Per accepted beat:
    - Compare rdata to expected. Mismatch, or rresp!=2'b00, or (rlast != (counter==0)) counts as one bad beat: error<=1, err_count+1 (saturating).
    - expected <= {expected[3:0], expected[31:4]}.
    - counter decrements.
  - Beat with counter==0 accepted (whether or not rlast was correct): rready=0, done=1, counter/expected reload, -> IDLE.
  - rvalid=0 cycles: no change (slave wait states are legal).
- Beats arriving while not in DATA are not accepted (rready=0); no check is made on them.
- start while not IDLE is ignored.
- done/error/err_count hold after completion until the next accepted start.
- Latency with zero-wait slave:
  - start sampled at cycle 0.
  - arvalid high at cycle 1; AR handshake at cycle 1.
  - rready high at cycle 2; first beat at cycle 2 or later.
  - done high one cycle after the last beat's handshake.
- Unknown state encoding -> IDLE.

Test Plan:
- Zero-wait slave returning correct pattern:
  - start -> one AR: araddr=0, arlen=0x0F, arburst=01, arsize=2.
  - 16 beats: beat0=0x12345678, beat1=0x81234567, beat2=0x78123456, beat15=0x23456781.
  - done=1, error=0, err_count=0.
- Backpressure: arready delayed 3 cycles; rvalid gaps of 0–4 random cycles -> arvalid stable until handshake; same pass result; exactly 16 beats accepted.
- Corruption:
  - rdata beat5 XOR 1 -> error=1, err_count=1, done=1 after beat15.
  - rresp=2'b10 on beat0 -> err_count=2 total after a fresh run with both faults.
- RLAST fault: rlast on beat14 and not beat15 -> err_count=2, error=1, done=1 after beat15.
- Rerun: second start after a failing run -> error/err_count/done cleared on accept; clean burst -> error=0.
- Reset mid-burst: rstn low after beat7 -> arvalid=rready=done=error=0 immediately. Then start -> fresh AR; beat0 expected 0x12345678 again; start asserted during DATA is ignored (single AR observed).
